reg_op_sequencer: RTL and testbench
===================================

Name: reg_op_sequencer

Overview:
- Control-side driver for the 4-bit X/Y/Z working registers.
- Accepts one command per handshake and expands it into a cycle-by-cycle sequence of register op codes on `Tx`, plus load data on `reg_in`.
- Sits between the instruction decoder and the register file.
- Reports completion with a one-cycle `done` pulse.

Parameters:
- W, 4, width of data to the register and of the shadow copy
- AMT_W, 2, width of the shift-amount field; amounts 0 to 2^AMT_W-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command request; sampled only when busy=0
- cmd  in  3  command code
- amt  in  AMT_W  shift count for shift commands
- din  in  W  load data for load commands
- Tx  out  3  register op code: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100
- reg_in  out  W  data presented to the register data input
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse together with done for a reserved cmd
- shadow  out  W  mirror of the register contents (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - Tx=HOLD, reg_in=0, busy=0, done=0, err=0, shadow=0, state=IDLE.
  - Takes effect mid-command: the sequence is abandoned and no done pulse is issued.
- Command codes and op sequences (N = op count):
  - 000 NOP: none, N=0.
  - 001 LOAD: LOAD, N=1.
  - 010 SHR: SHIFTR repeated amt times, N=amt.
  - 011 SHL: SHIFTL repeated amt times, N=amt.
  - 100 CLEAR: RESET, N=1.
  - 101 LDSHR: LOAD then amt × SHIFTR, N=1+amt.
  - 110 LDSHL: LOAD then amt × SHIFTL, N=1+amt.
  - 111 reserved: N=0, err=1.
- Accept: on the rising edge where start=1 and busy=0, cmd, amt and din are latched and the state leaves IDLE/DONE.
- Cycle timing: call the accept edge cycle 0.
  - Ops are driven on Tx in cycles 1..N, one op per cycle.
  - busy=1 in cycles 1..N.
  - reg_in = latched din for cycles 1..N; it holds that value afterwards until the next accept.
- Completion:
  - Cycle N+1: Tx=HOLD, busy=0, done=1 (err=1 if reserved).
  - N=0: done in cycle 1, busy never rises.
- States:
  - IDLE → LOADS (if cmd has load) → SHIFT (if remaining amt>0) → DONE.
  - CLEAR/LOAD-only commands go from their single op state directly to DONE.
  - DONE → IDLE after one cycle unless a new start is accepted.
- Back-to-back: start sampled in the DONE cycle is accepted; the next command's first op appears the following cycle, with no HOLD gap beyond the DONE cycle.
- Shift counter: a down-counter of AMT_W bits, loaded with the latched amt. It never wraps; SHIFT exits when the counter reaches 1 on the issuing cycle.
- start while busy=1: ignored, not queued. cmd, amt and din changes while busy have no effect.
- Tx outside SHIFT/LOADS/CLEAR cycles: always HOLD. The codes 101–111 are never driven.

Optional Feature:
- Macro: REG_OP_SHADOW_EN.
- Defined:
  - shadow tracks the register value, updated on the same clock edge the register consumes Tx.
  - LOAD → reg_in; SHIFTR → logical shift right by 1 with zero fill; SHIFTL → logical shift left by 1 with zero fill; RESET → 0; HOLD → unchanged.
  - shadow is reset to 0, which matches the register only after a CLEAR or LOAD has executed.
- Undefined: shadow is tied to 0 and no shadow logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset, then LOAD din=1011 → cycle 1 Tx=001, reg_in=1011, busy=1; cycle 2 Tx=000, done=1, busy=0; shadow=1011 with REG_OP_SHADOW_EN.
- LDSHR din=1100 amt=2 → Tx sequence 001, 010, 010, then done in cycle 4; shadow=0011.
- SHL amt=0 and cmd=111 → each produces no ops and done in cycle 1; err=1 only for 111.
- SHL amt=3 accepted, start pulsed again in cycles 1–3 → extra starts ignored; exactly three 011 codes, then one done.
- CLEAR, with a LOAD din=0110 started on the done cycle → Tx 100, 000(done), 001, 000(done); no other idle cycles.
- LDSHL amt=3 with rst_n dropped asynchronously mid-cycle 2 → Tx=000, busy=0 immediately; no done; after release, a new LOAD is accepted normally.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Control-side driver for the 4-bit X/Y/Z working registers. Accepts one
// command per start/busy handshake and expands it into a cycle-by-cycle
// sequence of register op codes on Tx, with the latched load data on reg_in.
// Completion is signalled by a one-cycle done pulse; err accompanies done
// for the reserved command code.
//
// Optional feature (macro REG_OP_SHADOW_EN):
//   defined   - shadow mirrors the register contents by replaying every op
//               on the same edge the register consumes it.
//   undefined - shadow is tied to zero and no shadow logic exists.
//   The port list is identical in both builds.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      command request, sampled only while busy=0
//   cmd     in   3      command code
//   amt     in   AMT_W  shift count for shift commands
//   din     in   W      load data for load commands
//   Tx      out  3      register op: HOLD=000 LOAD=001 SHIFTR=010
//                       SHIFTL=011 RESET=100
//   reg_in  out  W      data presented to the register data input
//   busy    out  1      command in progress (op cycles)
//   done    out  1      one-cycle completion pulse
//   err     out  1      one-cycle pulse with done for reserved cmd 111
//   shadow  out  W      mirror of the register contents
// ---------------------------------------------------------------------------
module reg_op_sequencer #(
    parameter int W     = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic [AMT_W-1:0] amt,
    input  logic [W-1:0]     din,
    output logic [2:0]       Tx,
    output logic [W-1:0]     reg_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     shadow
);

    // Register op codes
    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SHIFTR = 3'b010;
    localparam logic [2:0] OP_SHIFTL = 3'b011;
    localparam logic [2:0] OP_RESET  = 3'b100;

    // Command codes
    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_SHR   = 3'b010;
    localparam logic [2:0] CMD_SHL   = 3'b011;
    localparam logic [2:0] CMD_CLEAR = 3'b100;
    localparam logic [2:0] CMD_LDSHR = 3'b101;
    localparam logic [2:0] CMD_LDSHL = 3'b110;
    localparam logic [2:0] CMD_RSVD  = 3'b111;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADS = 3'd1,
        S_SHIFT = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_reg,  state_next;
    logic [AMT_W-1:0] cnt_reg,    cnt_next;    // remaining shift ops
    logic             left_reg,   left_next;   // shift direction of the command
    logic             err_reg,    err_next;    // command was the reserved code
    logic [W-1:0]     din_reg,    din_next;    // latched load data

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            left_reg  <= 1'b0;
            err_reg   <= 1'b0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            left_reg  <= left_next;
            err_reg   <= err_next;
            din_reg   <= din_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic. Outputs are decoded from the state so an
    // asynchronous reset forces Tx back to HOLD and busy low immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        left_next  = left_reg;
        err_next   = err_reg;
        din_next   = din_reg;
        Tx         = OP_HOLD;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (state_reg == S_DONE) begin
                    done = 1'b1;
                    err  = err_reg;
                end
                if (start) begin
                    // Accept: latch the whole command; later input changes
                    // have no effect until the next accept.
                    din_next  = din;
                    cnt_next  = amt;
                    err_next  = 1'b0;
                    left_next = (cmd == CMD_SHL) || (cmd == CMD_LDSHL);
                    case (cmd)
                        CMD_NOP: state_next = S_DONE;
                        CMD_LOAD: begin
                            cnt_next   = CNT_ZERO;  // load only, no shifts follow
                            state_next = S_LOADS;
                        end
                        CMD_SHR, CMD_SHL:
                            state_next = (amt == CNT_ZERO) ? S_DONE : S_SHIFT;
                        CMD_CLEAR: state_next = S_CLEAR;
                        CMD_LDSHR, CMD_LDSHL: state_next = S_LOADS;
                        CMD_RSVD: begin
                            err_next   = 1'b1;
                            state_next = S_DONE;
                        end
                        default: state_next = S_DONE;
                    endcase
                end else if (state_reg == S_DONE) begin
                    state_next = S_IDLE;
                end
            end

            S_LOADS: begin
                Tx         = OP_LOAD;
                busy       = 1'b1;
                state_next = (cnt_reg != CNT_ZERO) ? S_SHIFT : S_DONE;
            end

            S_SHIFT: begin
                // The counter is nonzero on entry and stops at 1, so it
                // never wraps through zero.
                Tx   = left_reg ? OP_SHIFTL : OP_SHIFTR;
                busy = 1'b1;
                if (cnt_reg == CNT_ONE) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            S_CLEAR: begin
                Tx         = OP_RESET;
                busy       = 1'b1;
                state_next = S_DONE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    // reg_in holds the latched data until the next accept.
    assign reg_in = din_reg;

    // -----------------------------------------------------------------------
    // Shadow copy of the register
    // -----------------------------------------------------------------------
`ifdef REG_OP_SHADOW_EN
    logic [W-1:0] shadow_reg, shadow_next;

    always_comb begin
        shadow_next = shadow_reg;
        case (Tx)
            OP_LOAD:   shadow_next = din_reg;
            OP_SHIFTR: shadow_next = {1'b0, shadow_reg[W-1:1]};
            OP_SHIFTL: shadow_next = {shadow_reg[W-2:0], 1'b0};
            OP_RESET:  shadow_next = '0;
            default:   shadow_next = shadow_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= shadow_next;
        end
    end

    assign shadow = shadow_reg;
`else
    assign shadow = '0;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
//
// Table of commands with their expected op count and error flag; each command
// is expanded by a small reference model into per-cycle expected outputs that
// are queued when the command is accepted and compared at the falling edge of
// every following cycle. Hand-written sequences cover ignored starts,
// back-to-back accepts and an asynchronous reset mid-command.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_SHIFTR = 3'b010;
    localparam logic [2:0] OP_SHIFTL = 3'b011;
    localparam logic [2:0] OP_RESET  = 3'b100;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] cmd;
    logic [1:0] amt;
    logic [3:0] din;
    logic [2:0] tx;
    logic [3:0] reg_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] shadow;

    reg_op_sequencer #(.W(4), .AMT_W(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmd    (cmd),
        .amt    (amt),
        .din    (din),
        .Tx     (tx),
        .reg_in (reg_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .shadow (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tx;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] reg_in;
        logic [3:0] shadow;
    } exp_t;

    typedef struct {
        logic [2:0] cmd;
        logic [1:0] amt;
        logic [3:0] din;
        int         n_ops;
        logic       err;
    } vec_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] msh      = 4'b0000;   // model of the register contents

    // ---------------- reference model ----------------
    function automatic logic [2:0] op_of(input logic [2:0] c, input int k);
        logic has_load;
        has_load = (c == 3'b001) || (c == 3'b101) || (c == 3'b110);
        if (c == 3'b100)            return OP_RESET;
        if (has_load && k == 1)     return OP_LOAD;
        if (c == 3'b010 || c == 3'b101) return OP_SHIFTR;
        return OP_SHIFTL;
    endfunction

    function automatic logic [3:0] apply(input logic [2:0] op, input logic [3:0] s,
                                         input logic [3:0] d);
        case (op)
            OP_LOAD:   return d;
            OP_SHIFTR: return {1'b0, s[3:1]};
            OP_SHIFTL: return {s[2:0], 1'b0};
            OP_RESET:  return 4'b0000;
            default:   return s;
        endcase
    endfunction

    function automatic logic [3:0] shx(input logic [3:0] s);
`ifdef REG_OP_SHADOW_EN
        return s;
`else
        return (s & 4'b0000);
`endif
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 1;
            if (tx !== e.tx || busy !== e.busy || done !== e.done || err !== e.err ||
                reg_in !== e.reg_in || shadow !== e.shadow) begin
                failures = failures + 1;
                $display("FAIL cycle%0d: got tx=%b busy=%b done=%b err=%b reg_in=%b shadow=%b, expected tx=%b busy=%b done=%b err=%b reg_in=%b shadow=%b",
                         cyc, tx, busy, done, err, reg_in, shadow,
                         e.tx, e.busy, e.done, e.err, e.reg_in, e.shadow);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Drive a command just after a rising edge; after the accepting edge,
    // queue the expected outputs for cycles 1..N+1 (plus one idle cycle).
    task automatic issue(input logic [2:0] c, input logic [1:0] a, input logic [3:0] d,
                         input int n, input logic e, input bit idle_after);
        logic [3:0] sh;
        logic [2:0] t;
        start = 1'b1;
        cmd   = c;
        amt   = a;
        din   = d;
        @(posedge clk);
        sh = msh;
        for (int k = 1; k <= n; k++) begin
            t = op_of(c, k);
            q.push_back('{t, 1'b1, 1'b0, 1'b0, d, shx(sh)});
            sh = apply(t, sh, d);
        end
        q.push_back('{OP_HOLD, 1'b0, 1'b1, e, d, shx(sh)});
        if (idle_after) q.push_back('{OP_HOLD, 1'b0, 1'b0, 1'b0, d, shx(sh)});
        msh = sh;
        #1;
        start = 1'b0;
        $display("txn cmd=%b amt=%0d din=%b ops=%0d err=%b", c, a, d, n, e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain_timeout: %0d expected cycles left, required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'b001, 2'd0, 4'b1011, 1, 1'b0};  // LOAD
        vecs[1] = '{3'b101, 2'd2, 4'b1100, 3, 1'b0};  // LDSHR amt 2
        vecs[2] = '{3'b011, 2'd0, 4'b0101, 0, 1'b0};  // SHL amt 0
        vecs[3] = '{3'b111, 2'd1, 4'b1110, 0, 1'b1};  // reserved
        vecs[4] = '{3'b000, 2'd3, 4'b0001, 0, 1'b0};  // NOP
        vecs[5] = '{3'b010, 2'd3, 4'b0010, 3, 1'b0};  // SHR amt 3
        vecs[6] = '{3'b110, 2'd1, 4'b0111, 2, 1'b0};  // LDSHL amt 1
        vecs[7] = '{3'b100, 2'd2, 4'b1000, 1, 1'b0};  // CLEAR
        vecs[8] = '{3'b101, 2'd3, 4'b1111, 4, 1'b0};  // LDSHR amt 3
        vecs[9] = '{3'b011, 2'd2, 4'b1001, 2, 1'b0};  // SHL amt 2

        rst_n = 1'b0;
        start = 1'b0;
        cmd   = 3'b000;
        amt   = 2'd0;
        din   = 4'b0000;
        #12;
        chk("reset_tx",     {1'b0, tx},     4'b0000);
        chk("reset_busy",   {3'b000, busy}, 4'b0000);
        chk("reset_done",   {3'b000, done}, 4'b0000);
        chk("reset_err",    {3'b000, err},  4'b0000);
        chk("reset_reg_in", reg_in,         4'b0000);
        chk("reset_shadow", shadow,         4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven commands
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].cmd, vecs[i].amt, vecs[i].din, vecs[i].n_ops, vecs[i].err, 1'b1);
            wait_drain();
        end

        // SHL amt=3 with start pulsed (carrying a LOAD) during the op cycles
        issue(3'b011, 2'd3, 4'b0101, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            cmd   = 3'b001;
            din   = 4'($urandom_range(0, 15));
            amt   = 2'd1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        q.push_back('{OP_HOLD, 1'b0, 1'b0, 1'b0, 4'b0101, shx(msh)});
        wait_drain();

        // CLEAR, then LOAD accepted in the done cycle
        issue(3'b100, 2'd0, 4'b1001, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        issue(3'b001, 2'd0, 4'b0110, 1, 1'b0, 1'b1);
        wait_drain();

        // LDSHL amt=3, asynchronous reset in the middle of cycle 2
        issue(3'b110, 2'd3, 4'b1010, 4, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        msh = 4'b0000;
        #1;
        chk("async_rst_tx",     {1'b0, tx},     4'b0000);
        chk("async_rst_busy",   {3'b000, busy}, 4'b0000);
        chk("async_rst_reg_in", reg_in,         4'b0000);
        chk("async_rst_shadow", shadow,         4'b0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_done", {3'b000, done}, 4'b0000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b001, 2'd0, 4'b0110, 1, 1'b0, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
